motor_homing_sequencer: RTL and testbench

MOTOR_HOMING_SEQUENCER -- requirements
Module: motor_homing_sequencer

---
 rtl/motor_homing_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_motor_homing_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_homing_sequencer.sv
// Stepper homing and positioning sequencer: homes against an end-stop, backs off,
// then executes absolute moves with step/dir pulses, pause and lost-step detection.
module motor_homing_sequencer #(
  parameter int unsigned STEP_HALF = 500,
  parameter int unsigned HOME_MAX  = 20000,
  parameter int unsigned BACKOFF   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        calib_start,
  input  logic        sensorFimCurso,
  input  logic        move_req,
  input  logic [15:0] target_pos,
  input  logic        trava_servo,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        calib_done,
  output logic        move_done,
  output logic        erro_homing,
  output logic [15:0] db_current_pos,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HOMING  = 4'd1,
    S_BACKOFF = 4'd2,
    S_READY   = 4'd3,
    S_MOVE    = 4'd4,
    S_DONE    = 4'd5,
    S_ERROR   = 4'd6
  } state_t;

  localparam int unsigned TW = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
  localparam int unsigned HW = $clog2(HOME_MAX + 1);
  localparam int unsigned BW = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(STEP_HALF - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOME_MAX);
  localparam logic [BW-1:0] B_MAX  = BW'(BACKOFF);

  state_t        state_q, state_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [15:0]   pos_q, pos_d;
  logic [15:0]   tgt_q, tgt_d;
  logic          calib_done_q, calib_done_d;
  logic          erro_q, erro_d;
  logic          sync1_q, sync2_q;
  logic          phase_adv, step_fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      timer_q      <= '0;
      hcnt_q       <= '0;
      bcnt_q       <= '0;
      pos_q        <= '0;
      tgt_q        <= '0;
      calib_done_q <= 1'b0;
      erro_q       <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      timer_q      <= timer_d;
      hcnt_q       <= hcnt_d;
      bcnt_q       <= bcnt_d;
      pos_q        <= pos_d;
      tgt_q        <= tgt_d;
      calib_done_q <= calib_done_d;
      erro_q       <= erro_d;
      sync1_q      <= sensorFimCurso;
      sync2_q      <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    dir_d        = dir_q;
    timer_d      = timer_q;
    hcnt_d       = hcnt_q;
    bcnt_d       = bcnt_q;
    pos_d        = pos_q;
    tgt_d        = tgt_q;
    calib_done_d = calib_done_q;
    erro_d       = erro_q;
    phase_adv    = 1'b0;
    step_fall    = 1'b0;

    case (state_q)
      S_HOMING, S_BACKOFF, S_MOVE: begin
        // A low phase with timer 0 is the decision point before a new pulse;
        // the high phase always runs to completion regardless of trava_servo.
        if (step_q) begin
          phase_adv = 1'b1;
        end else if (timer_q != '0) begin
          phase_adv = !trava_servo;
        end else begin
          case (state_q)
            S_HOMING: begin
              if (sync2_q) begin
                pos_d   = '0;
                dir_d   = 1'b1;
                bcnt_d  = '0;
                state_d = S_BACKOFF;
              end else if (hcnt_q == H_MAX) begin
                state_d = S_ERROR;
              end else begin
                phase_adv = !trava_servo;
              end
            end
            S_BACKOFF: begin
              if (bcnt_q == B_MAX) begin
                state_d      = S_READY;
                calib_done_d = 1'b1;
              end else begin
                phase_adv = !trava_servo;
              end
            end
            default: begin
              if (pos_q == tgt_q) state_d = S_DONE;
              else phase_adv = !trava_servo;
            end
          endcase
        end

        if (phase_adv) begin
          if (timer_q == T_LAST) begin
            timer_d   = '0;
            step_d    = !step_q;
            step_fall = step_q;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        if (step_fall) begin
          case (state_q)
            S_HOMING:  hcnt_d = hcnt_q + HW'(1);
            S_BACKOFF: begin
              bcnt_d = bcnt_q + BW'(1);
              pos_d  = pos_q + 16'd1;
            end
            default:   pos_d = dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
          endcase
        end

        // Sensor hit while travelling toward it away from zero means lost steps.
        if (state_q == S_MOVE && sync2_q && !dir_q && pos_q != '0) state_d = S_ERROR;

        if (state_d == S_ERROR) begin
          step_d       = 1'b0;
          timer_d      = '0;
          erro_d       = 1'b1;
          calib_done_d = 1'b0;
        end
      end

      default: begin
        if (state_q == S_DONE) state_d = S_READY;
        if (state_q == S_READY && move_req && calib_done_q) begin
          tgt_d = target_pos;
          if (target_pos == pos_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MOVE;
            dir_d   = (target_pos > pos_q);
            timer_d = '0;
            step_d  = 1'b0;
          end
        end
        if (calib_start) begin
          state_d      = S_HOMING;
          calib_done_d = 1'b0;
          erro_d       = 1'b0;
          hcnt_d       = '0;
          dir_d        = 1'b0;
          timer_d      = '0;
          step_d       = 1'b0;
        end
      end
    endcase
  end

  assign step           = step_q;
  assign dir            = dir_q;
  assign busy           = (state_q == S_HOMING) || (state_q == S_BACKOFF) || (state_q == S_MOVE);
  assign calib_done     = calib_done_q;
  assign move_done      = (state_q == S_DONE);
  assign erro_homing    = erro_q;
  assign db_current_pos = pos_q;
  assign db_estado      = state_q;

endmodule

// File: tb/tb_motor_homing_sequencer.sv
// Bench for motor_homing_sequencer: pulse counting monitor plus a position model
// driven by randomized homing points and move targets.
module tb_motor_homing_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        calib_start = 1'b0;
  logic        sensorFimCurso = 1'b0;
  logic        move_req = 1'b0;
  logic [15:0] target_pos = '0;
  logic        trava_servo = 1'b0;
  logic        step, dir, busy, calib_done, move_done, erro_homing;
  logic [15:0] db_current_pos;
  logic [3:0]  db_estado;

  int checks = 0;
  int failures = 0;
  int pulses_up = 0;
  int pulses_dn = 0;
  logic prev_step = 1'b0;
  int exp_pos = 0;

  motor_homing_sequencer #(.STEP_HALF(2), .HOME_MAX(40), .BACKOFF(4)) dut (
    .clock(clock), .reset(reset), .calib_start(calib_start),
    .sensorFimCurso(sensorFimCurso), .move_req(move_req), .target_pos(target_pos),
    .trava_servo(trava_servo), .step(step), .dir(dir), .busy(busy),
    .calib_done(calib_done), .move_done(move_done), .erro_homing(erro_homing),
    .db_current_pos(db_current_pos), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Counts step pulses by their rising edge, classified by dir at that moment.
  always @(negedge clock) begin
    if (step && !prev_step) begin
      if (dir) pulses_up++;
      else pulses_dn++;
    end
    prev_step = step;
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (db_estado == s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_move(input logic [15:0] tgt, output int up, output int dn,
                         output int dones, output bit ok);
    int bu, bd;
    bu = pulses_up;
    bd = pulses_dn;
    target_pos = tgt;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    dones = 0;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (move_done) dones++;
      if (dones > 0 && db_estado == 4'd3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    up = pulses_up - bu;
    dn = pulses_dn - bd;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    checks++;
    if ({step, dir, busy, calib_done, move_done, erro_homing} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000", {step, dir, busy, calib_done, move_done, erro_homing});
    end
    checks++;
    if (db_current_pos !== 16'd0 || db_estado !== 4'd0) begin
      failures++;
      $display("FAIL reset_pos_state: got pos=%0d st=%0d want 0/0", db_current_pos, db_estado);
    end
    reset = 1'b1;
    tick();
    target_pos = 16'd5;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_move_ignored: got st=%0d busy=%0d want 0/0", db_estado, busy);
    end
  endtask

  task automatic test_homing(input int n);
    int bu, bd, up, dn;
    bit ok;
    bu = pulses_up;
    bd = pulses_dn;
    calib_start = 1'b1;
    tick();
    calib_start = 1'b0;
    checks++;
    if (db_estado !== 4'd1 || busy !== 1'b1 || dir !== 1'b0 || erro_homing !== 1'b0 || calib_done !== 1'b0) begin
      failures++;
      $display("FAIL homing_entry: got st=%0d busy=%0d dir=%0d err=%0d cd=%0d want 1/1/0/0/0",
               db_estado, busy, dir, erro_homing, calib_done);
    end
    ok = 1'b0;
    for (int i = 0; i < n * 4 + 40; i++) begin
      if (pulses_dn - bd >= n && step == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL homing_pulses_timeout: got %0d pulses want %0d", pulses_dn - bd, n);
    end
    sensorFimCurso = 1'b1;
    wait_state(4'd3, 120, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL homing_ready_timeout: got st=%0d want 3", db_estado);
    end
    up = pulses_up - bu;
    dn = pulses_dn - bd;
    checks++;
    if (dn < n || dn > n + 1) begin
      failures++;
      $display("FAIL homing_dn_pulses: got %0d want %0d..%0d", dn, n, n + 1);
    end
    checks++;
    if (up !== 4) begin
      failures++;
      $display("FAIL backoff_pulses: got %0d want 4", up);
    end
    checks++;
    if (db_current_pos !== 16'd4 || calib_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL homing_result: got pos=%0d cd=%0d busy=%0d want 4/1/0", db_current_pos, calib_done, busy);
    end
    sensorFimCurso = 1'b0;
    repeat (4) tick();
    exp_pos = 4;
  endtask

  task automatic test_moves;
    int up, dn, dones;
    bit ok;
    do_move(16'd10, up, dn, dones, ok);
    checks++;
    if (!ok || up !== 6 || dn !== 0 || dones !== 1 || db_current_pos !== 16'd10) begin
      failures++;
      $display("FAIL move_4_to_10: got ok=%0d up=%0d dn=%0d done=%0d pos=%0d want 1/6/0/1/10",
               ok, up, dn, dones, db_current_pos);
    end
    do_move(16'd2, up, dn, dones, ok);
    checks++;
    if (!ok || up !== 0 || dn !== 8 || dones !== 1 || db_current_pos !== 16'd2) begin
      failures++;
      $display("FAIL move_10_to_2: got ok=%0d up=%0d dn=%0d done=%0d pos=%0d want 1/0/8/1/2",
               ok, up, dn, dones, db_current_pos);
    end
    do_move(16'd2, up, dn, dones, ok);
    checks++;
    if (!ok || up + dn !== 0 || dones !== 1 || db_current_pos !== 16'd2) begin
      failures++;
      $display("FAIL move_same_target: got ok=%0d pulses=%0d done=%0d pos=%0d want 1/0/1/2",
               ok, up + dn, dones, db_current_pos);
    end
    exp_pos = 2;
  endtask

  task automatic test_random_moves;
    int up, dn, dones, eu, ed, tgt;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      tgt = $urandom_range(0, 50);
      eu = (tgt > exp_pos) ? tgt - exp_pos : 0;
      ed = (tgt < exp_pos) ? exp_pos - tgt : 0;
      do_move(16'(tgt), up, dn, dones, ok);
      checks++;
      if (!ok || up !== eu || dn !== ed || dones !== 1 || db_current_pos !== 16'(tgt)) begin
        failures++;
        $display("FAIL random_move_%0d: got ok=%0d up=%0d dn=%0d done=%0d pos=%0d want 1/%0d/%0d/1/%0d",
                 k, ok, up, dn, dones, db_current_pos, eu, ed, tgt);
      end
      exp_pos = tgt;
    end
  endtask

  task automatic test_pause;
    int up, dn, dones, bu, held;
    bit ok;
    do_move(16'd4, up, dn, dones, ok);
    checks++;
    if (!ok || db_current_pos !== 16'd4) begin
      failures++;
      $display("FAIL pause_setup: got ok=%0d pos=%0d want 1/4", ok, db_current_pos);
    end
    bu = pulses_up;
    target_pos = 16'd10;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (step && (pulses_up - bu) == 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    trava_servo = 1'b1;
    for (int i = 0; i < 6 && step; i++) tick();
    checks++;
    if (!ok || step !== 1'b0) begin
      failures++;
      $display("FAIL pause_pulse_completes: got found=%0d step=%0d want 1/0", ok, step);
    end
    held = pulses_up;
    repeat (20) tick();
    checks++;
    if (pulses_up !== held || step !== 1'b0 || db_estado !== 4'd4) begin
      failures++;
      $display("FAIL pause_hold: got new_pulses=%0d step=%0d st=%0d want 0/0/4",
               pulses_up - held, step, db_estado);
    end
    trava_servo = 1'b0;
    dones = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (move_done) dones++;
      if (dones > 0 && db_estado == 4'd3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || pulses_up - bu !== 6 || dones !== 1 || db_current_pos !== 16'd10) begin
      failures++;
      $display("FAIL pause_resume: got ok=%0d pulses=%0d done=%0d pos=%0d want 1/6/1/10",
               ok, pulses_up - bu, dones, db_current_pos);
    end
    exp_pos = 10;
  endtask

  task automatic test_calib_ignored_in_move;
    int bu, dones;
    bit ok;
    bu = pulses_up;
    target_pos = 16'(exp_pos + 12);
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    for (int i = 0; i < 40 && (pulses_up - bu) < 3; i++) tick();
    calib_start = 1'b1;
    tick();
    calib_start = 1'b0;
    checks++;
    if (db_estado !== 4'd4 || dir !== 1'b1) begin
      failures++;
      $display("FAIL calib_ignored_state: got st=%0d dir=%0d want 4/1", db_estado, dir);
    end
    dones = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (move_done) dones++;
      if (dones > 0 && db_estado == 4'd3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || pulses_up - bu !== 12 || db_current_pos !== 16'(exp_pos + 12) || calib_done !== 1'b1) begin
      failures++;
      $display("FAIL calib_ignored_move: got ok=%0d pulses=%0d pos=%0d cd=%0d want 1/12/%0d/1",
               ok, pulses_up - bu, db_current_pos, calib_done, exp_pos + 12);
    end
    exp_pos = exp_pos + 12;
  endtask

  task automatic test_timeout;
    int bu, bd, held;
    bit ok;
    bu = pulses_up;
    bd = pulses_dn;
    sensorFimCurso = 1'b0;
    calib_start = 1'b1;
    tick();
    calib_start = 1'b0;
    wait_state(4'd6, 300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_error_state: got st=%0d want 6", db_estado);
    end
    checks++;
    if (pulses_dn - bd !== 40 || pulses_up - bu !== 0) begin
      failures++;
      $display("FAIL timeout_pulses: got dn=%0d up=%0d want 40/0", pulses_dn - bd, pulses_up - bu);
    end
    checks++;
    if (erro_homing !== 1'b1 || step !== 1'b0 || busy !== 1'b0 || calib_done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flags: got err=%0d step=%0d busy=%0d cd=%0d want 1/0/0/0",
               erro_homing, step, busy, calib_done);
    end
    held = pulses_up + pulses_dn;
    target_pos = 16'd7;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (db_estado !== 4'd6 || pulses_up + pulses_dn !== held || erro_homing !== 1'b1) begin
      failures++;
      $display("FAIL error_move_ignored: got st=%0d new_pulses=%0d err=%0d want 6/0/1",
               db_estado, pulses_up + pulses_dn - held, erro_homing);
    end
  endtask

  task automatic test_lost_step;
    int up, dn, dones;
    bit ok;
    do_move(16'd20, up, dn, dones, ok);
    checks++;
    if (!ok || db_current_pos !== 16'd20) begin
      failures++;
      $display("FAIL lost_step_setup: got ok=%0d pos=%0d want 1/20", ok, db_current_pos);
    end
    target_pos = 16'd0;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (db_current_pos == 16'd5) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    sensorFimCurso = 1'b1;
    for (int i = 0; i < 3 && db_estado != 4'd6; i++) tick();
    checks++;
    if (!ok || db_estado !== 4'd6) begin
      failures++;
      $display("FAIL lost_step_error: got reached5=%0d st=%0d want 1/6", ok, db_estado);
    end
    checks++;
    if (erro_homing !== 1'b1 || step !== 1'b0 || calib_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lost_step_flags: got err=%0d step=%0d cd=%0d busy=%0d want 1/0/0/0",
               erro_homing, step, calib_done, busy);
    end
    sensorFimCurso = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_move;
    bit ok;
    target_pos = 16'd30;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (step && db_current_pos >= 16'd8) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (!ok || {step, dir, busy, calib_done, move_done, erro_homing} !== 6'b0 ||
        db_current_pos !== 16'd0 || db_estado !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_move: got inpulse=%0d flags=%b pos=%0d st=%0d want 1/000000/0/0",
               ok, {step, dir, busy, calib_done, move_done, erro_homing}, db_current_pos, db_estado);
    end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    target_pos = 16'd9;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (db_estado !== 4'd0 || step !== 1'b0 || calib_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_move_ignored: got st=%0d step=%0d cd=%0d want 0/0/0",
               db_estado, step, calib_done);
    end
  endtask

  initial begin
    test_reset();
    test_homing(10);
    test_moves();
    test_random_moves();
    test_pause();
    test_calib_ignored_in_move();
    test_timeout();
    test_homing($urandom_range(1, 30));
    test_lost_step();
    test_homing($urandom_range(1, 30));
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
